id_ex_stage: RTL and testbench

//  ID/EX pipeline register of the RV32I pipelined core. Latches the decode-stage control

---
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: latches the decode control word and operands,
// detects load-use hazards, and applies flush and back-pressure to the Execute stage.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcAD,
  input  logic [1:0]       ALUSrcBD,
  input  logic [3:0]       ALUControlD,
  input  logic [2:0]       funct3D,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             FlushE,
  input  logic             StallE,
  output logic             RegWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcAE,
  output logic [1:0]       ALUSrcBE,
  output logic [3:0]       ALUControlE,
  output logic [2:0]       funct3E,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic             StallF,
  output logic             StallD,
  output logic [CNT_W-1:0] BubbleCnt
);

  localparam int unsigned REG_W = 5;
  localparam logic [1:0] RES_MEM = 2'b01;

  typedef struct packed {
    logic             reg_write;
    logic [1:0]       result_src;
    logic             mem_write;
    logic             jump;
    logic             branch;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_control;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  imm_ext;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } ex_t;

  ex_t              ex_in_c;
  ex_t              ex_q, ex_d;
  logic             valid_q, valid_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lw_stall_c;

  // Pack the decode-stage inputs into one payload word.
  always_comb begin
    ex_in_c.reg_write   = RegWriteD;
    ex_in_c.result_src  = ResultSrcD;
    ex_in_c.mem_write   = MemWriteD;
    ex_in_c.jump        = JumpD;
    ex_in_c.branch      = BranchD;
    ex_in_c.alu_src_a   = ALUSrcAD;
    ex_in_c.alu_src_b   = ALUSrcBD;
    ex_in_c.alu_control = ALUControlD;
    ex_in_c.funct3      = funct3D;
    ex_in_c.rd1         = RD1D;
    ex_in_c.rd2         = RD2D;
    ex_in_c.pc          = PCD;
    ex_in_c.pc_plus4    = PCPlus4D;
    ex_in_c.imm_ext     = ImmExtD;
    ex_in_c.rs1         = Rs1D;
    ex_in_c.rs2         = Rs2D;
    ex_in_c.rd          = RdD;
  end

  // A load in E whose destination is read by the instruction in D.
  always_comb begin
    lw_stall_c = valid_q & ex_q.reg_write & (ex_q.result_src == RES_MEM) &
                 (ex_q.rd != REG_W'(0)) & ((ex_q.rd == Rs1D) | (ex_q.rd == Rs2D));
  end

  // Next state: stall holds (remembering any flush), flush/hazard bubbles, else capture.
  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (StallE) begin
      if (FlushE) begin
        pend_d = 1'b1;
      end
    end else if (FlushE | pend_q | lw_stall_c) begin
      ex_d    = '0;
      valid_d = 1'b0;
      pend_d  = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d    = ex_in_c;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RegWriteE   = ex_q.reg_write;
  assign ResultSrcE  = ex_q.result_src;
  assign MemWriteE   = ex_q.mem_write;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign ALUSrcAE    = ex_q.alu_src_a;
  assign ALUSrcBE    = ex_q.alu_src_b;
  assign ALUControlE = ex_q.alu_control;
  assign funct3E     = ex_q.funct3;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign ImmExtE     = ex_q.imm_ext;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign ValidE      = valid_q;
  assign StallF      = lw_stall_c | StallE;
  assign StallD      = lw_stall_c | StallE;
  assign BubbleCnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/flush scenarios plus random traffic,
// checked against a cycle-level reference model of the stage's rules.
module tb_id_ex_stage;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic   chk;
    instr_t e;
    logic   v;
    logic   stall;
    int     cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcAD;
  logic [1:0] ResultSrcD, ALUSrcBD;
  logic [3:0] ALUControlD;
  logic [2:0] funct3D;
  logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic FlushE, StallE;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE;
  logic [1:0] ResultSrcE, ALUSrcBE;
  logic [3:0] ALUControlE;
  logic [2:0] funct3E;
  logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic ValidE, StallF, StallD;
  logic [CNT_W-1:0] BubbleCnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD),
    .ALUControlD(ALUControlD), .funct3D(funct3D), .RD1D(RD1D), .RD2D(RD2D),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .FlushE(FlushE), .StallE(StallE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .ALUControlE(ALUControlE), .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .StallF(StallF), .StallD(StallD), .BubbleCnt(BubbleCnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  exp_t exp_q[$];

  // Reference model state: contents of E, valid, pending flush, saturating bubble count.
  instr_t m_e;
  logic   m_v;
  logic   m_pend;
  int     m_cnt;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  function automatic instr_t mk(input logic rw, input logic [1:0] rsrc,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2);
    instr_t r;
    r.reg_write   = rw;
    r.result_src  = rsrc;
    r.mem_write   = 1'b0;
    r.jump        = 1'b0;
    r.branch      = 1'b0;
    r.alu_src_a   = 1'b0;
    r.alu_src_b   = 2'($urandom_range(0, 3));
    r.alu_control = 4'($urandom_range(0, 15));
    r.funct3      = 3'($urandom_range(0, 7));
    r.rd1         = $urandom;
    r.rd2         = $urandom;
    r.pc          = $urandom;
    r.pc_plus4    = r.pc + 32'd4;
    r.imm_ext     = $urandom;
    r.rs1         = rs1;
    r.rs2         = rs2;
    r.rd          = rd;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    r.mem_write = 1'($urandom_range(0, 1));
    r.jump      = 1'($urandom_range(0, 1));
    r.branch    = 1'($urandom_range(0, 1));
    r.alu_src_a = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Present one cycle of inputs, record what the DUT must show this cycle, advance the model.
  task automatic step(input instr_t in, input logic fl, input logic st, input logic rs,
                      input logic chk);
    exp_t x;
    logic lw;
    RegWriteD = in.reg_write;   ResultSrcD = in.result_src; MemWriteD = in.mem_write;
    JumpD = in.jump;            BranchD = in.branch;        ALUSrcAD = in.alu_src_a;
    ALUSrcBD = in.alu_src_b;    ALUControlD = in.alu_control; funct3D = in.funct3;
    RD1D = in.rd1;              RD2D = in.rd2;              PCD = in.pc;
    PCPlus4D = in.pc_plus4;     ImmExtD = in.imm_ext;
    Rs1D = in.rs1;              Rs2D = in.rs2;              RdD = in.rd;
    FlushE = fl;                StallE = st;                reset = rs;
    lw = m_v && m_e.reg_write && (m_e.result_src == 2'b01) && (m_e.rd != 5'd0) &&
         ((m_e.rd == in.rs1) || (m_e.rd == in.rs2));
    x.chk = chk; x.e = m_e; x.v = m_v; x.stall = lw || st; x.cnt = m_cnt;
    exp_q.push_back(x);
    if (rs) begin
      m_e = '0; m_v = 1'b0; m_pend = 1'b0; m_cnt = 0;
    end else if (st) begin
      if (fl) m_pend = 1'b1;
    end else if (fl || m_pend || lw) begin
      m_e = '0; m_v = 1'b0; m_pend = 1'b0;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else begin
      m_e = in; m_v = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t x;
    instr_t d;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (x.chk) begin
        d.reg_write = RegWriteE;   d.result_src = ResultSrcE; d.mem_write = MemWriteE;
        d.jump = JumpE;            d.branch = BranchE;        d.alu_src_a = ALUSrcAE;
        d.alu_src_b = ALUSrcBE;    d.alu_control = ALUControlE; d.funct3 = funct3E;
        d.rd1 = RD1E;              d.rd2 = RD2E;              d.pc = PCE;
        d.pc_plus4 = PCPlus4E;     d.imm_ext = ImmExtE;
        d.rs1 = Rs1E;              d.rs2 = Rs2E;              d.rd = RdE;
        check("e_payload", 192'(d), 192'(x.e));
        check("valid_e", 192'(ValidE), 192'(x.v));
        check("stall_f", 192'(StallF), 192'(x.stall));
        check("stall_d", 192'(StallD), 192'(x.stall));
        check("bubble_cnt", 192'(BubbleCnt), 192'(x.cnt));
      end
    end
  end

  initial begin
    instr_t ones, nop, a, b;
    ones = '1;
    nop  = '0;
    m_e = '0; m_v = 1'b0; m_pend = 1'b0; m_cnt = 0;
    @(posedge clk);
    #1;

    // Reset with all-ones decode inputs.
    step(ones, 1'b0, 1'b0, 1'b1, 1'b0);
    step(ones, 1'b0, 1'b0, 1'b1, 1'b1);
    step(nop,  1'b0, 1'b0, 1'b0, 1'b1);

    // add x3,x1,x2 pass-through.
    a = mk(1'b1, 2'b00, 5'd3, 5'd1, 5'd2);
    a.alu_control = 4'd0;
    step(a,   1'b0, 1'b0, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b0, 1'b0, 1'b1);

    // lw x5 then add x6,x5,x1: add is held in D for one bubble.
    a = mk(1'b1, 2'b01, 5'd5, 5'd2, 5'd0);
    b = mk(1'b1, 2'b00, 5'd6, 5'd5, 5'd1);
    step(a, 1'b0, 1'b0, 1'b0, 1'b1);
    step(b, 1'b0, 1'b0, 1'b0, 1'b1);
    step(b, 1'b0, 1'b0, 1'b0, 1'b1);

    // lw x0 then add x6,x0,x1: no hazard.
    a = mk(1'b1, 2'b01, 5'd0, 5'd2, 5'd0);
    b = mk(1'b1, 2'b00, 5'd6, 5'd0, 5'd1);
    step(a, 1'b0, 1'b0, 1'b0, 1'b1);
    step(b, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush pulse during a 3-cycle back-pressure stall.
    a = mk(1'b1, 2'b00, 5'd7, 5'd1, 5'd2);
    step(a,   1'b0, 1'b0, 1'b0, 1'b1);
    step(nop, 1'b1, 1'b1, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b1, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b1, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b0, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush coinciding with a load-use hazard.
    a = mk(1'b1, 2'b01, 5'd8, 5'd1, 5'd1);
    b = mk(1'b1, 2'b00, 5'd9, 5'd8, 5'd8);
    step(a,   1'b0, 1'b0, 1'b0, 1'b1);
    step(b,   1'b1, 1'b0, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset asserted while a load-use stall is active.
    a = mk(1'b1, 2'b01, 5'd9, 5'd1, 5'd1);
    b = mk(1'b1, 2'b00, 5'd10, 5'd9, 5'd2);
    step(a, 1'b0, 1'b0, 1'b0, 1'b1);
    step(b, 1'b0, 1'b0, 1'b1, 1'b1);
    step(b, 1'b0, 1'b0, 1'b0, 1'b1);
    step(b, 1'b0, 1'b0, 1'b0, 1'b1);

    // Drive the counter into saturation.
    for (int i = 0; i < CNT_MAX + 4; i++) step(nop, 1'b1, 1'b0, 1'b0, 1'b1);

    // Random traffic biased toward hazards on x0..x3.
    for (int i = 0; i < 400; i++) begin
      step(rand_instr(), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0),
           1'($urandom_range(0, 99) == 0), 1'b1);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drain", 192'(exp_q.size()), 192'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
